// File: rtl/pipeline_fifo_if.sv
// Handshake bundle between a producer/consumer pair and pipeline_fifo.
// The master side drives requests and payload; the slave side is the FIFO.
interface pipeline_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             enq_en;
    logic [WIDTH-1:0] enq_data;
    logic             not_full;
    logic             deq_en;
    logic [WIDTH-1:0] first;
    logic             not_empty;
    logic             clear;
    logic [CNT_W-1:0] count;

    modport master (
        output enq_en,
        output enq_data,
        output deq_en,
        output clear,
        input  not_full,
        input  first,
        input  not_empty,
        input  count
    );

    modport slave (
        input  enq_en,
        input  enq_data,
        input  deq_en,
        input  clear,
        output not_full,
        output first,
        output not_empty,
        output count
    );
endinterface

// File: rtl/pipeline_fifo.sv
// Pipeline FIFO with deq < enq < clear ordering inside one cycle: a dequeue
// in the same cycle frees the slot an enqueue needs, so a full FIFO still streams.
module pipeline_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    pipeline_fifo_if.slave  fifo
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [WIDTH-1:0] mem_q [DEPTH];

    ptr_t enq_ptr_q;
    ptr_t enq_ptr_d;
    ptr_t deq_ptr_q;
    ptr_t deq_ptr_d;
    logic empty_q;
    logic empty_d;
    logic full_q;
    logic full_d;

    logic             deq_fire_s;
    logic             enq_fire_s;
    logic             not_full_s;
    logic             mem_we_s;
    ptr_t             enq_ptr_inc_s;
    ptr_t             deq_ptr_inc_s;
    ptr_t             ptr_diff_s;
    logic [CNT_W-1:0] count_s;

    // Handshake decode: deq sees registered state, enq sees the post-deq view.
    always_comb begin
        deq_fire_s    = fifo.deq_en & ~empty_q;
        not_full_s    = ~full_q | deq_fire_s;
        enq_fire_s    = fifo.enq_en & not_full_s;
        mem_we_s      = enq_fire_s & ~fifo.clear;
        enq_ptr_inc_s = enq_ptr_q + ptr_t'(1);
        deq_ptr_inc_s = deq_ptr_q + ptr_t'(1);
        ptr_diff_s    = enq_ptr_q - deq_ptr_q;
        if (full_q) begin
            count_s = CNT_W'(DEPTH);
        end else begin
            count_s = CNT_W'(ptr_diff_s);
        end
    end

    // Next-state for pointers and flags; clear lands on the reset state.
    always_comb begin
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        empty_d   = empty_q;
        full_d    = full_q;
        if (fifo.clear) begin
            enq_ptr_d = '0;
            deq_ptr_d = '0;
            empty_d   = 1'b1;
            full_d    = 1'b0;
        end else begin
            case ({enq_fire_s, deq_fire_s})
                2'b10: begin
                    enq_ptr_d = enq_ptr_inc_s;
                    empty_d   = 1'b0;
                    full_d    = (enq_ptr_inc_s == deq_ptr_q);
                end
                2'b01: begin
                    deq_ptr_d = deq_ptr_inc_s;
                    full_d    = 1'b0;
                    empty_d   = (deq_ptr_inc_s == enq_ptr_q);
                end
                2'b11: begin
                    // Occupancy is unchanged, so both flags simply hold.
                    enq_ptr_d = enq_ptr_inc_s;
                    deq_ptr_d = deq_ptr_inc_s;
                end
                default: begin
                    enq_ptr_d = enq_ptr_q;
                    deq_ptr_d = deq_ptr_q;
                end
            endcase
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
        end
    end

    // Payload storage; left unreset since flags alone define validity.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[enq_ptr_q] <= fifo.enq_data;
        end
    end

    assign fifo.not_empty = ~empty_q;
    assign fifo.first     = mem_q[deq_ptr_q];
    assign fifo.not_full  = not_full_s;
    assign fifo.count     = count_s;
endmodule

// File: tb/tb_pipeline_fifo.sv
// Randomised and directed bench for pipeline_fifo, checked every cycle
// against a queue-based model of FIFO occupancy and ordering.
module tb_pipeline_fifo;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [WIDTH-1:0] model_q[$];

    pipeline_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ff ();

    pipeline_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fifo  (ff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: commit one cycle of deq-then-enq-then-clear.
    always @(posedge clk) begin
        if (rst_n) begin
            bit dq;
            bit eq;
            dq = ff.deq_en && (model_q.size() > 0);
            eq = ff.enq_en && ((model_q.size() < DEPTH) || dq);
            if (ff.clear) begin
                model_q.delete();
            end else begin
                if (dq) void'(model_q.pop_front());
                if (eq) model_q.push_back(ff.enq_data);
            end
        end
    end

    always @(negedge rst_n) model_q.delete();

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_count", 32'(ff.count), 32'(model_q.size()));
            chk("cmp_not_empty", 32'(ff.not_empty), 32'(model_q.size() > 0));
            chk("cmp_not_full", 32'(ff.not_full),
                32'((model_q.size() < DEPTH) || (ff.deq_en && model_q.size() > 0)));
            if (model_q.size() > 0) chk("cmp_first", 32'(ff.first), 32'(model_q[0]));
        end
    end

    task automatic drive(input logic e, input logic [WIDTH-1:0] d, input logic de, input logic cl);
        ff.enq_en   = e;
        ff.enq_data = d;
        ff.deq_en   = de;
        ff.clear    = cl;
    endtask

    // Drive one cycle's inputs and advance past the committing edge.
    task automatic step(input logic e, input logic [WIDTH-1:0] d, input logic de, input logic cl);
        drive(e, d, de, cl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_settle();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #12;
        chk("rst_not_empty", 32'(ff.not_empty), 32'd0);
        chk("rst_not_full", 32'(ff.not_full), 32'd1);
        chk("rst_count", 32'(ff.count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 1..4.
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        idle_settle();
        chk("fill_count", 32'(ff.count), 32'd4);
        chk("fill_not_full", 32'(ff.not_full), 32'd0);
        chk("fill_first", 32'(ff.first), 32'h1);

        // Enq into a full FIFO without deq is dropped.
        step(1'b1, 4'h9, 1'b0, 1'b0);
        idle_settle();
        chk("full_drop_count", 32'(ff.count), 32'd4);
        chk("full_drop_first", 32'(ff.first), 32'h1);

        // Simultaneous deq+enq while full.
        drive(1'b1, 4'h5, 1'b1, 1'b0);
        #1;
        chk("pass_not_full", 32'(ff.not_full), 32'd1);
        chk("pass_count_same", 32'(ff.count), 32'd4);
        @(posedge clk);
        #1;
        idle_settle();
        chk("pass_count_after", 32'(ff.count), 32'd4);
        chk("pass_first_after", 32'(ff.first), 32'h2);

        // Drain: 0x5 must come out fourth.
        for (int i = 0; i < 4; i++) begin
            idle_settle();
            chk("drain_order", 32'(ff.first), (i == 3) ? 32'h5 : 32'(i + 2));
            step(1'b0, 4'h0, 1'b1, 1'b0);
        end

        // Deq on empty is ignored; enq 0xA has no bypass to first.
        step(1'b0, 4'h0, 1'b1, 1'b0);
        idle_settle();
        chk("empty_deq_not_empty", 32'(ff.not_empty), 32'd0);
        chk("empty_deq_count", 32'(ff.count), 32'd0);
        drive(1'b1, 4'hA, 1'b0, 1'b0);
        #1;
        chk("no_bypass", 32'(ff.not_empty), 32'd0);
        @(posedge clk);
        #1;
        idle_settle();
        chk("enq_a_first", 32'(ff.first), 32'hA);
        chk("enq_a_not_empty", 32'(ff.not_empty), 32'd1);

        // Two entries, then clear together with enq and deq.
        step(1'b1, 4'hB, 1'b0, 1'b0);
        drive(1'b1, 4'hC, 1'b1, 1'b1);
        #1;
        chk("clear_pre_count", 32'(ff.count), 32'd2);
        chk("clear_pre_first", 32'(ff.first), 32'hA);
        @(posedge clk);
        #1;
        idle_settle();
        chk("clear_count", 32'(ff.count), 32'd0);
        chk("clear_not_empty", 32'(ff.not_empty), 32'd0);
        chk("clear_not_full", 32'(ff.not_full), 32'd1);

        // Random traffic with a mid-stream asynchronous reset.
        for (int n = 0; n < 300; n++) begin
            if (n == 150) begin
                drive(1'b0, 4'h0, 1'b0, 1'b0);
                #2;
                rst_n = 1'b0;
                #1;
                chk("async_rst_count", 32'(ff.count), 32'd0);
                chk("async_rst_not_empty", 32'(ff.not_empty), 32'd0);
                chk("async_rst_not_full", 32'(ff.not_full), 32'd1);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            step(1'($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) == 0));
        end
        idle_settle();
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
